// File: rtl/sample_deframer_if.sv
// Handshake bundle for sample_deframer: FT245 byte input on one side,
// channel-tagged sample output on the other.
interface sample_deframer_if #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int CW           = 2
) ();
  logic [7:0]              rx_data_si;
  logic                    rx_valid_si;
  logic                    rx_ready_si;
  logic [SAMPLE_WIDTH-1:0] sample_o;
  logic [CW-1:0]           chan_o;
  logic                    sample_valid_o;
  logic                    sample_ready_i;

  modport slave (
    input  rx_data_si, rx_valid_si, sample_ready_i,
    output rx_ready_si, sample_o, chan_o, sample_valid_o
  );

  modport master (
    output rx_data_si, rx_valid_si, sample_ready_i,
    input  rx_ready_si, sample_o, chan_o, sample_valid_o
  );
endinterface

// File: rtl/sample_deframer.sv
// Host byte-stream deframer: sync/header/length/payload/checksum parsing,
// little-endian sample assembly with channel tags, status pulses and counters.
module sample_deframer #(
  parameter int         SAMPLE_WIDTH = 16,
  parameter int         NUM_CHANNELS = 4,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         TIMEOUT_CLKS = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  sample_deframer_if.slave      bus,
  output logic                  busy_o,
  output logic                  frame_done_o,
  output logic                  crc_err_o,
  output logic                  chan_err_o,
  output logic                  timeout_o,
  output logic [15:0]           frame_count_o,
  output logic [15:0]           err_count_o
);
  localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int SB = SAMPLE_WIDTH / 8;
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);

  typedef enum logic [2:0] {HUNT, HEADER, LENGTH, PAYLOAD, CHECK} state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           chan_q, chan_d;
  logic                    drop_q, drop_d;
  logic [8:0]              rem_q, rem_d;
  logic [1:0]              bcnt_q, bcnt_d;
  logic [SAMPLE_WIDTH-1:0] shift_q, shift_d;
  logic [7:0]              csum_q, csum_d;
  logic [TW-1:0]           tmo_q, tmo_d;
  logic [SAMPLE_WIDTH-1:0] sample_q, sample_d;
  logic [CW-1:0]           schan_q, schan_d;
  logic                    svalid_q, svalid_d;
  logic                    frame_done_q, frame_done_d;
  logic                    crc_err_q, crc_err_d;
  logic                    chan_err_q, chan_err_d;
  logic                    timeout_q, timeout_d;
  logic [15:0]             frame_cnt_q, frame_cnt_d;
  logic [15:0]             err_cnt_q, err_cnt_d;

  logic                    rx_ready_s, accept_s, emit_s, err_inc_s;
  logic [SAMPLE_WIDTH-1:0] shift_next_s;

  assign rx_ready_s   = !svalid_q | bus.sample_ready_i;
  assign accept_s     = bus.rx_valid_si & rx_ready_s;
  // New byte enters at the top so the first byte ends up as the LSB.
  assign shift_next_s = SAMPLE_WIDTH'({bus.rx_data_si, shift_q} >> 8);

  always_comb begin
    state_d      = state_q;
    chan_d       = chan_q;
    drop_d       = drop_q;
    rem_d        = rem_q;
    bcnt_d       = bcnt_q;
    shift_d      = shift_q;
    csum_d       = csum_q;
    tmo_d        = tmo_q;
    sample_d     = sample_q;
    schan_d      = schan_q;
    svalid_d     = svalid_q;
    frame_done_d = 1'b0;
    crc_err_d    = 1'b0;
    chan_err_d   = 1'b0;
    timeout_d    = 1'b0;
    emit_s       = 1'b0;
    err_inc_s    = 1'b0;

    case (state_q)
      HUNT: begin
        if (accept_s && bus.rx_data_si == SYNC_BYTE) begin
          state_d = HEADER;
          csum_d  = 8'h00;
          drop_d  = 1'b0;
          bcnt_d  = 2'd0;
        end
      end
      HEADER: begin
        if (accept_s) begin
          csum_d  = csum_q ^ bus.rx_data_si;
          chan_d  = bus.rx_data_si[CW-1:0];
          state_d = LENGTH;
          if ({1'b0, bus.rx_data_si[3:0]} >= 5'(NUM_CHANNELS)) begin
            drop_d     = 1'b1;
            chan_err_d = 1'b1;
          end
        end
      end
      LENGTH: begin
        if (accept_s) begin
          csum_d  = csum_q ^ bus.rx_data_si;
          rem_d   = (bus.rx_data_si == 8'h00) ? 9'd256 : {1'b0, bus.rx_data_si};
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (accept_s) begin
          csum_d  = csum_q ^ bus.rx_data_si;
          shift_d = shift_next_s;
          if (bcnt_q == 2'(SB - 1)) begin
            bcnt_d = 2'd0;
            emit_s = !drop_q;
            rem_d  = rem_q - 9'd1;
            if (rem_q == 9'd1) begin
              state_d = CHECK;
            end
          end else begin
            bcnt_d = bcnt_q + 2'd1;
          end
        end
      end
      CHECK: begin
        if (accept_s) begin
          state_d = HUNT;
          if (bus.rx_data_si != csum_q) begin
            crc_err_d = 1'b1;
            err_inc_s = 1'b1;
          end else if (drop_q) begin
            err_inc_s = 1'b1;
          end else begin
            frame_done_d = 1'b1;
          end
        end
      end
      default: state_d = HUNT;
    endcase

    // Idle timer only runs inside a frame and freezes under back-pressure.
    if (state_q == HUNT) begin
      tmo_d = '0;
    end else if (accept_s) begin
      tmo_d = '0;
    end else if (rx_ready_s && !bus.rx_valid_si) begin
      if (tmo_q == TW'(TIMEOUT_CLKS - 1)) begin
        timeout_d = 1'b1;
        err_inc_s = 1'b1;
        state_d   = HUNT;
        tmo_d     = '0;
        bcnt_d    = 2'd0;
        shift_d   = '0;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end else begin
      tmo_d = tmo_q;
    end

    if (emit_s) begin
      sample_d = shift_next_s;
      schan_d  = chan_q;
      svalid_d = 1'b1;
    end else if (bus.sample_ready_i) begin
      svalid_d = 1'b0;
    end else begin
      svalid_d = svalid_q;
    end

    frame_cnt_d = (frame_done_d && frame_cnt_q != 16'hFFFF) ? frame_cnt_q + 16'd1 : frame_cnt_q;
    err_cnt_d   = (err_inc_s && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= HUNT;
      chan_q       <= '0;
      drop_q       <= 1'b0;
      rem_q        <= 9'd0;
      bcnt_q       <= 2'd0;
      shift_q      <= '0;
      csum_q       <= 8'h00;
      tmo_q        <= '0;
      sample_q     <= '0;
      schan_q      <= '0;
      svalid_q     <= 1'b0;
      frame_done_q <= 1'b0;
      crc_err_q    <= 1'b0;
      chan_err_q   <= 1'b0;
      timeout_q    <= 1'b0;
      frame_cnt_q  <= 16'd0;
      err_cnt_q    <= 16'd0;
    end else begin
      state_q      <= state_d;
      chan_q       <= chan_d;
      drop_q       <= drop_d;
      rem_q        <= rem_d;
      bcnt_q       <= bcnt_d;
      shift_q      <= shift_d;
      csum_q       <= csum_d;
      tmo_q        <= tmo_d;
      sample_q     <= sample_d;
      schan_q      <= schan_d;
      svalid_q     <= svalid_d;
      frame_done_q <= frame_done_d;
      crc_err_q    <= crc_err_d;
      chan_err_q   <= chan_err_d;
      timeout_q    <= timeout_d;
      frame_cnt_q  <= frame_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign bus.rx_ready_si    = rx_ready_s;
  assign bus.sample_o       = sample_q;
  assign bus.chan_o         = schan_q;
  assign bus.sample_valid_o = svalid_q;
  assign busy_o             = (state_q != HUNT);
  assign frame_done_o       = frame_done_q;
  assign crc_err_o          = crc_err_q;
  assign chan_err_o         = chan_err_q;
  assign timeout_o          = timeout_q;
  assign frame_count_o      = frame_cnt_q;
  assign err_count_o        = err_cnt_q;
endmodule

// File: tb/tb_sample_deframer.sv
// Scoreboard bench for sample_deframer: directed frames push expected samples
// and status events; a negedge monitor pops and compares on every output.
module tb_sample_deframer;
  localparam int SW = 16;
  localparam int CW = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        busy_o, frame_done_o, crc_err_o, chan_err_o, timeout_o;
  logic [15:0] frame_count_o, err_count_o;

  sample_deframer_if #(.SAMPLE_WIDTH(SW), .CW(CW)) bus ();

  sample_deframer #(
    .SAMPLE_WIDTH(SW), .NUM_CHANNELS(4), .SYNC_BYTE(8'hA5), .TIMEOUT_CLKS(16)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .busy_o(busy_o), .frame_done_o(frame_done_o), .crc_err_o(crc_err_o),
    .chan_err_o(chan_err_o), .timeout_o(timeout_o),
    .frame_count_o(frame_count_o), .err_count_o(err_count_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [CW+SW-1:0] sq[$];
  logic [3:0]       evq[$];
  logic [7:0]       frm[$];

  localparam logic [3:0] EV_DONE = 4'b0001;
  localparam logic [3:0] EV_CRC  = 4'b0010;
  localparam logic [3:0] EV_CHAN = 4'b0100;
  localparam logic [3:0] EV_TMO  = 4'b1000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (bus.sample_valid_o && bus.sample_ready_i) begin
        if (sq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL sample_unexpected: got %0h, expected none", {bus.chan_o, bus.sample_o});
        end else begin
          chk("sample", 32'({bus.chan_o, bus.sample_o}), 32'(sq.pop_front()));
        end
      end
      if ({timeout_o, chan_err_o, crc_err_o, frame_done_o} != 4'b0000) begin
        if (evq.size() == 0) begin
          chk("status_unexpected", 32'({timeout_o, chan_err_o, crc_err_o, frame_done_o}), 32'd0);
        end else begin
          chk("status", 32'({timeout_o, chan_err_o, crc_err_o, frame_done_o}), 32'(evq.pop_front()));
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    logic acc;
    int   budget;
    bus.rx_data_si  = b;
    bus.rx_valid_si = 1'b1;
    acc    = 1'b0;
    budget = 0;
    while (!acc && budget < 200) begin
      @(negedge clk);
      acc = bus.rx_ready_si;
      @(posedge clk);
      #1;
      budget++;
    end
    if (!acc) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: byte %0h not accepted, expected acceptance", b);
    end
  endtask

  task automatic send_frm();
    foreach (frm[i]) send_byte(frm[i]);
  endtask

  task automatic idle(input int n);
    bus.rx_valid_si = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_sample"}, 32'(bus.sample_o), 32'd0);
    chk({tag, "_chan"}, 32'(bus.chan_o), 32'd0);
    chk({tag, "_valid"}, 32'(bus.sample_valid_o), 32'd0);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_pulses"}, 32'({timeout_o, chan_err_o, crc_err_o, frame_done_o}), 32'd0);
    chk({tag, "_fcnt"}, 32'(frame_count_o), 32'd0);
    chk({tag, "_ecnt"}, 32'(err_count_o), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.rx_valid_si = 1'b0;
    #2;
    check_zero("reset");
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic push_good();
    sq.push_back({2'd2, 16'h1234});
    sq.push_back({2'd2, 16'h5678});
    evq.push_back(EV_DONE);
  endtask

  task automatic counts(input string tag, input logic [15:0] f, input logic [15:0] e);
    chk({tag, "_fcnt"}, 32'(frame_count_o), 32'(f));
    chk({tag, "_ecnt"}, 32'(err_count_o), 32'(e));
  endtask

  initial begin
    bus.rx_data_si     = 8'h00;
    bus.rx_valid_si    = 1'b0;
    bus.sample_ready_i = 1'b1;
    #3;
    do_reset();

    // 1: good frame with leading junk
    push_good();
    frm = '{8'h00, 8'hFF, 8'hA5, 8'h02, 8'h02, 8'h34, 8'h12, 8'h78, 8'h56, 8'h08};
    send_frm();
    idle(3);
    counts("t1", 16'd1, 16'd0);
    chk("t1_busy", 32'(busy_o), 32'd0);

    // 2: bad checksum, samples still delivered
    do_reset();
    sq.push_back({2'd2, 16'h1234});
    sq.push_back({2'd2, 16'h5678});
    evq.push_back(EV_CRC);
    frm = '{8'hA5, 8'h02, 8'h02, 8'h34, 8'h12, 8'h78, 8'h56, 8'h09};
    send_frm();
    idle(3);
    counts("t2", 16'd0, 16'd1);

    // 3: out-of-range channel, frame consumed, no samples
    do_reset();
    evq.push_back(EV_CHAN);
    frm = '{8'hA5, 8'h07, 8'h01, 8'hAA, 8'hBB, 8'h17};
    send_frm();
    idle(3);
    counts("t3", 16'd0, 16'd1);
    chk("t3_busy", 32'(busy_o), 32'd0);

    // 4: back-pressure after the first sample
    do_reset();
    push_good();
    frm = '{8'hA5, 8'h02, 8'h02, 8'h34, 8'h12};
    send_frm();
    bus.sample_ready_i = 1'b0;
    bus.rx_data_si     = 8'h78;
    repeat (4) @(negedge clk);
    chk("t4_hold_sample", 32'(bus.sample_o), 32'h1234);
    chk("t4_hold_valid", 32'(bus.sample_valid_o), 32'd1);
    chk("t4_rx_ready", 32'(bus.rx_ready_si), 32'd0);
    @(posedge clk);
    #1 bus.sample_ready_i = 1'b1;
    frm = '{8'h78, 8'h56, 8'h08};
    send_frm();
    idle(3);
    counts("t4", 16'd1, 16'd0);

    // 5: idle timeout mid-payload, then recovery
    do_reset();
    evq.push_back(EV_TMO);
    frm = '{8'hA5, 8'h02, 8'h02};
    send_frm();
    idle(20);
    chk("t5_busy", 32'(busy_o), 32'd0);
    counts("t5a", 16'd0, 16'd1);
    push_good();
    frm = '{8'h00, 8'hFF, 8'hA5, 8'h02, 8'h02, 8'h34, 8'h12, 8'h78, 8'h56, 8'h08};
    send_frm();
    idle(3);
    counts("t5b", 16'd1, 16'd1);

    // 6: asynchronous reset mid-frame with non-zero counters
    frm = '{8'hA5, 8'h02, 8'h02, 8'h34};
    send_frm();
    #2 rst = 1'b0;
    bus.rx_valid_si = 1'b0;
    #1;
    check_zero("t6_async");
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    push_good();
    frm = '{8'h00, 8'hFF, 8'hA5, 8'h02, 8'h02, 8'h34, 8'h12, 8'h78, 8'h56, 8'h08};
    send_frm();
    idle(3);
    counts("t6", 16'd1, 16'd0);

    chk("sample_queue_drained", 32'(sq.size()), 32'd0);
    chk("event_queue_drained", 32'(evq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/sample_deframer.md
Name: sample_deframer

Overview:
- Sits between the FT245 simple-interface RX port and the per-channel sample FIFOs feeding the modulators.
- Parses a framed host byte stream: sync, header, length, payload, checksum.
- Assembles multi-byte samples of parametrised width and tags each with a channel number.
- Reports frame and error status through pulses and saturating counters.
- Replaces the current direct byte-to-FIFO path so one USB link can feed several channels with wider samples.

Parameters:
- SAMPLE_WIDTH, 16: sample width in bits; multiple of 8, range 8..32. SAMPLE_BYTES = SAMPLE_WIDTH/8.
- NUM_CHANNELS, 4: number of valid channels, range 1..16. CW = max(1, clog2(NUM_CHANNELS)).
- SYNC_BYTE, 8'hA5: frame start marker.
- TIMEOUT_CLKS, 1024: number of idle cycles inside a frame before the frame is aborted.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- rx_data_si  in  8  byte from the FT245 wrapper
- rx_valid_si  in  1  byte valid
- rx_ready_si  out  1  byte accepted when rx_valid_si & rx_ready_si
- sample_o  out  SAMPLE_WIDTH  assembled sample
- chan_o  out  CW  channel tag for sample_o
- sample_valid_o  out  1  sample handshake valid
- sample_ready_i  in  1  sample handshake ready
- busy_o  out  1  high while state != HUNT
- frame_done_o  out  1  one-cycle pulse: good frame completed
- crc_err_o  out  1  one-cycle pulse: checksum mismatch
- chan_err_o  out  1  one-cycle pulse: channel in header out of range
- timeout_o  out  1  one-cycle pulse: frame aborted on idle timeout
- frame_count_o  out  16  good-frame count, saturates at 16'hFFFF
- err_count_o  out  16  errored-frame count (crc, channel or timeout), saturates at 16'hFFFF

Behaviour:
- Reset (rst low, asynchronous):
  - state goes to HUNT.
  - All outputs are 0, including counters, sample_o and chan_o.
  - Partial sample, checksum and timeout counter are cleared.
- rx_ready_si = !sample_valid_o | sample_ready_i. Combinational, applies in every state.
- Output register: sample_valid_o, once set, holds with sample_o and chan_o stable until sample_ready_i is high. It is then cleared, unless a new sample completes in the same cycle, in which case it reloads.
- HUNT:
  - Accepted bytes other than SYNC_BYTE are discarded.
  - SYNC_BYTE -> HEADER; checksum accumulator cleared.
- HEADER:
  - chan = byte[3:0].
  - If chan >= NUM_CHANNELS: chan_err_o pulses the next cycle and the drop flag is set. The frame is still consumed in full, but no samples are emitted.
  - Next state LENGTH.
- LENGTH:
  - N = byte; 0 means 256 samples.
  - Next state PAYLOAD.
- PAYLOAD:
  - Bytes are shifted in little-endian (first byte is the LSB).
  - On the SAMPLE_BYTES-th byte, the sample is loaded into the output register the next cycle with sample_valid_o = 1 (suppressed if the drop flag is set).
  - After N samples -> CHECK.
- CHECK: the byte is compared with the XOR of the header, length and all payload bytes.
  - Match and no drop: frame_done_o pulses and frame_count_o increments.
  - Match with drop: err_count_o increments only.
  - Mismatch: crc_err_o pulses and err_count_o increments.
  - A frame that is both dropped and mismatched counts once.
  - Next state HUNT.
- Latency:
  - Sample: 1 cycle from acceptance of its last byte to sample_valid_o.
  - Status pulses: 1 cycle after the checksum byte is accepted.
- Timeout:
  - Outside HUNT, a counter increments each cycle in which rx_ready_si = 1 and rx_valid_si = 0.
  - The counter clears on any accepted byte. It holds, without incrementing, while back-pressured.
  - On reaching TIMEOUT_CLKS: timeout_o pulses, err_count_o increments, state -> HUNT, and the partial sample is discarded.
  - An already-valid output sample is still delivered.
- SYNC_BYTE inside a frame is treated as data; there is no resynchronisation mid-frame.
- Counters saturate and never wrap.
- Samples already emitted from a frame that later fails its checksum are not retracted. Downstream relies on crc_err_o.

Test Plan:
(SAMPLE_WIDTH=16, NUM_CHANNELS=4, TIMEOUT_CLKS=16, sample_ready_i=1 unless stated)
1. Bytes 00 FF A5 02 02 34 12 78 56 08 -> leading 00 FF ignored; two samples 0x1234 then 0x5678, both chan_o=2; frame_done_o pulses; frame_count_o=1; err_count_o=0.
2. Same frame with checksum 09 -> both samples still emitted; crc_err_o pulses; frame_done_o stays low; err_count_o=1.
3. A5 07 01 AA BB 17 (valid XOR) -> chan_err_o pulses after the header; no sample_valid_o; at CHECK frame_done_o stays low; err_count_o=1.
4. Test 1 with sample_ready_i low after the first sample -> sample_o holds 0x1234 and rx_ready_si=0 while stalled; raising sample_ready_i completes the frame with both samples in order.
5. A5 02 02 then 16 idle cycles -> timeout_o pulses; busy_o=0; err_count_o=1; a following good frame from test 1 is accepted; frame_count_o=1.
6. rst low after byte 34 of test 1 -> all outputs 0 immediately; after release the full test 1 frame yields 0x1234 and 0x5678, with no stale data.
